// File: rtl/sram_frame_arbiter.sv
// Four-phase time-sliced arbiter for one asynchronous SRAM: a VGA read slot and a round-robin
// write slot per period, with hidden-frame clear and deferred double-buffer swap.
module sram_frame_arbiter #(
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned DW       = 16,
  parameter int unsigned XW       = 10,
  parameter int unsigned YW       = 9,
  parameter int unsigned AW       = 20,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                 sram_clk,
  input  logic                 reset_n,
  input  logic                 frame_tick,
  input  logic [NUM_WR-1:0]    wr_req,
  input  logic [NUM_WR*XW-1:0] wr_x,
  input  logic [NUM_WR*YW-1:0] wr_y,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic [NUM_WR-1:0]    wr_ack,
  input  logic                 rd_req,
  input  logic [XW-1:0]        rd_x,
  input  logic [YW-1:0]        rd_y,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid,
  input  logic                 clear_start,
  input  logic [DW-1:0]        clear_data,
  output logic                 clear_busy,
  output logic                 display_frame,
  output logic                 swap_pending,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_WE_N,
  output logic [AW-1:0]        SRAM_ADDR,
  inout  wire  [DW-1:0]        SRAM_DQ
);

  localparam int unsigned LGW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

  typedef enum logic [1:0] {RSetup, RStrobe, WSetup, WStrobe} phase_e;

  phase_e          ph_q, ph_d;
  logic            rd_active_q;
  logic            wr_active_q;
  logic            clr_slot_q;
  logic [DW-1:0]   dq_q;
  logic [LGW-1:0]  last_grant_q;
  logic [XW-1:0]   cx_q;
  logic [YW-1:0]   cy_q;

  logic            grant_found;
  logic [LGW-1:0]  grant_idx;
  logic [LGW-1:0]  rr_idx;

  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = wr_active_q ? dq_q : {DW{1'bz}};

  always_comb begin
    ph_d = ph_q;
    unique case (ph_q)
      RSetup:  ph_d = RStrobe;
      RStrobe: ph_d = WSetup;
      WSetup:  ph_d = WStrobe;
      WStrobe: ph_d = RSetup;
      default: ph_d = RSetup;
    endcase
  end

  // Round-robin search starting just after the previous winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    for (int unsigned k = 1; k <= NUM_WR; k++) begin
      rr_idx = LGW'((32'(last_grant_q) + k) % NUM_WR);
      if (!grant_found && wr_req[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      ph_q         <= RSetup;
      rd_active_q  <= 1'b0;
      wr_active_q  <= 1'b0;
      clr_slot_q   <= 1'b0;
      dq_q         <= '0;
      last_grant_q <= LGW'(NUM_WR - 1);
      SRAM_OE_N    <= 1'b1;
      SRAM_WE_N    <= 1'b1;
      SRAM_ADDR    <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      wr_ack       <= '0;
    end else begin
      ph_q <= ph_d;
      unique case (ph_q)
        RSetup: ;
        RStrobe: begin
          if (rd_active_q) rd_data <= SRAM_DQ;
          rd_valid    <= rd_active_q;
          rd_active_q <= 1'b0;
          SRAM_OE_N   <= 1'b1;
          if (grant_found) begin
            SRAM_ADDR    <= {~display_frame, wr_y[32'(grant_idx)*YW +: YW],
                             wr_x[32'(grant_idx)*XW +: XW]};
            dq_q         <= wr_data[32'(grant_idx)*DW +: DW];
            wr_active_q  <= 1'b1;
            wr_ack       <= NUM_WR'(1) << grant_idx;
            last_grant_q <= grant_idx;
          end else if (clear_busy) begin
            SRAM_ADDR   <= {~display_frame, cy_q, cx_q};
            dq_q        <= clear_data;
            wr_active_q <= 1'b1;
            clr_slot_q  <= 1'b1;
          end
        end
        WSetup: begin
          rd_valid  <= 1'b0;
          wr_ack    <= '0;
          SRAM_WE_N <= ~wr_active_q;
        end
        WStrobe: begin
          SRAM_WE_N   <= 1'b1;
          wr_active_q <= 1'b0;
          clr_slot_q  <= 1'b0;
          if (rd_req) begin
            SRAM_ADDR   <= {display_frame, rd_y, rd_x};
            SRAM_OE_N   <= 1'b0;
            rd_active_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      clear_busy <= 1'b0;
      cx_q       <= '0;
      cy_q       <= '0;
    end else if (!clear_busy) begin
      if (clear_start) begin
        clear_busy <= 1'b1;
        cx_q       <= '0;
        cy_q       <= '0;
      end
    end else if (ph_q == WStrobe && clr_slot_q) begin
      if (cx_q == XW'(H_ACTIVE - 1)) begin
        cx_q <= '0;
        if (cy_q == YW'(V_ACTIVE - 1)) clear_busy <= 1'b0;
        else cy_q <= cy_q + 1'b1;
      end else begin
        cx_q <= cx_q + 1'b1;
      end
    end
  end

  // A tick landing on the swap edge re-arms the pending flag for the next period.
  always_ff @(posedge sram_clk or negedge reset_n) begin
    if (!reset_n) begin
      display_frame <= 1'b0;
      swap_pending  <= 1'b0;
    end else if (ph_q == WStrobe && swap_pending && !clear_busy) begin
      display_frame <= ~display_frame;
      swap_pending  <= frame_tick;
    end else if (frame_tick) begin
      swap_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Bench for sram_frame_arbiter: behavioural SRAM model, phase tracker and scoreboard queues.
module tb_sram_frame_arbiter;
  localparam int unsigned NW = 2;
  localparam int unsigned DW = 16;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 20;
  localparam int unsigned HA = 16;
  localparam int unsigned VA = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, frame_tick, rd_req, clear_start;
  logic [NW-1:0]    wr_req, wr_ack;
  logic [NW*XW-1:0] wr_x;
  logic [NW*YW-1:0] wr_y;
  logic [NW*DW-1:0] wr_data;
  logic [XW-1:0]    rd_x;
  logic [YW-1:0]    rd_y;
  logic [DW-1:0]    rd_data, clear_data;
  logic             rd_valid, clear_busy, df, sp;
  logic             ce_n, ub_n, lb_n, oe_n, we_n;
  logic [AW-1:0]    addr;
  wire  [DW-1:0]    sram_dq;

  sram_frame_arbiter #(
    .NUM_WR(NW), .DW(DW), .XW(XW), .YW(YW), .AW(AW), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .sram_clk(clk), .reset_n(rst_n), .frame_tick(frame_tick),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y), .rd_data(rd_data), .rd_valid(rd_valid),
    .clear_start(clear_start), .clear_data(clear_data), .clear_busy(clear_busy),
    .display_frame(df), .swap_pending(sp),
    .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_OE_N(oe_n),
    .SRAM_WE_N(we_n), .SRAM_ADDR(addr), .SRAM_DQ(sram_dq)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign sram_dq = (!oe_n && we_n) ? mem[addr] : 'z;
  always @(posedge clk) if (!we_n) mem[addr] <= sram_dq;

  int tb_ph;
  int cyc = 0;
  int n_wr = 0;
  logic [AW-1:0] last_wr_addr;
  logic [DW-1:0] last_wr_data;
  always @(posedge clk or negedge rst_n) if (!rst_n) tb_ph <= 0; else tb_ph <= (tb_ph + 1) % 4;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!we_n) begin
    n_wr         <= n_wr + 1;
    last_wr_addr <= addr;
    last_wr_data <= sram_dq;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_df = 1'b0;
  logic [DW-1:0] rd_q[$];
  int ack_q[$];

  task automatic wait_ph(input int p);
    int n = 0;
    @(negedge clk);
    while (tb_ph != p && n < 8) begin @(negedge clk); n++; end
    if (tb_ph != p) begin
      n_tests++; n_fail++;
      $display("FAIL phase_sync got %0d want %0d", tb_ph, p);
    end
  endtask

  task automatic do_read(input logic [XW-1:0] x, input logic [YW-1:0] y,
                         input logic [DW-1:0] d, input string nm);
    int n = 0;
    wait_ph(3);
    rd_req = 1'b1; rd_x = x; rd_y = y;
    rd_q.push_back(d);
    do begin @(negedge clk); n++; end while (!rd_valid && n < 10);
    rd_req = 1'b0;
    n_tests++;
    if (!rd_valid) begin
      n_fail++; void'(rd_q.pop_front());
      $display("FAIL %s_timeout rd_valid never rose", nm);
    end else begin
      logic [DW-1:0] e;
      e = rd_q.pop_front();
      if (rd_data !== e) begin n_fail++; $display("FAIL %s_data got %h want %h", nm, rd_data, e); end
      n_tests++;
      if (n != 3 || tb_ph != 2) begin
        n_fail++; $display("FAIL %s_latency got %0d cycles ph%0d want 3 cycles ph2", nm, n, tb_ph);
      end
      @(negedge clk);
      n_tests++;
      if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL %s_pulse got %b want 0", nm, rd_valid); end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame_tick = 0; rd_req = 0; clear_start = 0; wr_req = '0;
    wr_x = '0; wr_y = '0; wr_data = '0; rd_x = '0; rd_y = '0; clear_data = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({oe_n, we_n, ce_n, ub_n, lb_n, rd_valid, df, sp, clear_busy} !== 9'b110000000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 110000000",
               {oe_n, we_n, ce_n, ub_n, lb_n, rd_valid, df, sp, clear_busy});
    end
    n_tests++;
    if (addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
    n_tests++;
    if (wr_ack !== '0) begin n_fail++; $display("FAIL reset_ack got %b want 0", wr_ack); end
    n_tests++;
    if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    rst_n = 1'b1;
  endtask

  task automatic test_read;
    logic [XW-1:0] xs [3] = '{10'd7, 10'd300, 10'd639};
    logic [YW-1:0] ys [3] = '{9'd5, 9'd100, 9'd479};
    logic [DW-1:0] ds [3] = '{16'hA5A5, 16'h5A3C, 16'h0FF0};
    for (int i = 0; i < 3; i++) begin
      mem[{1'b0, ys[i], xs[i]}] = ds[i];
      mem[{1'b1, ys[i], xs[i]}] = ~ds[i];
      do_read(xs[i], ys[i], ds[i], "read");
    end
  endtask

  task automatic test_round_robin;
    wait_ph(0);
    wr_req = 2'b11;
    wr_x = {10'd9, 10'd3}; wr_y = {9'd2, 9'd4}; wr_data = {16'h2222, 16'h1111};
    ack_q = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      int e;
      wait_ph(2);
      e = ack_q.pop_front();
      n_tests++;
      if (wr_ack !== (NW'(1) << e) || we_n !== 1'b1) begin
        n_fail++; $display("FAIL rr_ack%0d got ack=%b we_n=%b want ack=%b we_n=1",
                           i, wr_ack, we_n, NW'(1) << e);
      end
      if (i == 3) wr_req = '0;
      wait_ph(3);
      n_tests++;
      if (wr_ack !== '0 || we_n !== 1'b0) begin
        n_fail++; $display("FAIL rr_strobe%0d got ack=%b we_n=%b want ack=0 we_n=0", i, wr_ack, we_n);
      end
    end
    wait_ph(0);
    n_tests++;
    if (mem[{1'b1, 9'd4, 10'd3}] !== 16'h1111 || mem[{1'b1, 9'd2, 10'd9}] !== 16'h2222) begin
      n_fail++; $display("FAIL rr_mem got %h %h want 1111 2222",
                         mem[{1'b1, 9'd4, 10'd3}], mem[{1'b1, 9'd2, 10'd9}]);
    end
  endtask

  task automatic test_swap;
    wait_ph(0);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    n_tests++;
    if (sp !== 1'b1 || df !== exp_df) begin
      n_fail++; $display("FAIL swap_pend got sp=%b df=%b want sp=1 df=%b", sp, df, exp_df);
    end
    wait_ph(0);
    exp_df = ~exp_df;
    n_tests++;
    if (df !== exp_df || sp !== 1'b0) begin
      n_fail++; $display("FAIL swap_toggle got df=%b sp=%b want df=%b sp=0", df, sp, exp_df);
    end
    do_read(10'd3, 9'd4, 16'h1111, "swap_read");
    wait_ph(0);
    wr_req = 2'b01; wr_x = {10'd0, 10'd5}; wr_y = {9'd0, 9'd5}; wr_data = {16'h0, 16'h7777};
    wait_ph(2);
    wr_req = '0;
    wait_ph(0);
    n_tests++;
    if (mem[{1'b0, 9'd5, 10'd5}] !== 16'h7777) begin
      n_fail++; $display("FAIL swap_write got %h want 7777", mem[{1'b0, 9'd5, 10'd5}]);
    end
  endtask

  task automatic test_clear_priority;
    int start_wr, nc, p, bad;
    logic req;
    for (int y = 0; y < int'(VA); y++)
      for (int x = 0; x < int'(HA); x++) mem[{1'b0, 9'(y), 10'(x)}] = 16'hDEAD;
    wait_ph(0);
    clear_data = 16'h001F; clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    start_wr = n_wr; nc = 0;
    for (p = 0; p < 400; p++) begin
      wait_ph(0);
      if (!clear_busy) break;
      req = 1'b0;
      if (p % 2 == 0 && nc < 10) begin
        wr_req = 2'b01; wr_x[0 +: XW] = 10'(20 + nc); wr_y[0 +: YW] = 9'(nc);
        wr_data[0 +: DW] = 16'hC000 + 16'(nc);
        ack_q.push_back(0); req = 1'b1;
      end
      wait_ph(2);
      if (req) begin
        int e;
        e = ack_q.pop_front();
        n_tests++;
        if (wr_ack !== (NW'(1) << e)) begin
          n_fail++; $display("FAIL clr_prio%0d got %b want %b", nc, wr_ack, NW'(1) << e);
        end
        wr_req = '0; nc++;
      end
    end
    n_tests++;
    if (p >= 400) begin n_fail++; $display("FAIL clr_timeout clear_busy still %b", clear_busy); end
    n_tests++;
    if (last_wr_addr !== {1'b0, 9'(VA - 1), 10'(HA - 1)} || last_wr_data !== 16'h001F) begin
      n_fail++; $display("FAIL clr_last got %h:%h want %h:001F", last_wr_addr, last_wr_data,
                         {1'b0, 9'(VA - 1), 10'(HA - 1)});
    end
    n_tests++;
    if (n_wr - start_wr != int'(HA * VA) + nc) begin
      n_fail++; $display("FAIL clr_count got %0d want %0d", n_wr - start_wr, HA * VA + nc);
    end
    bad = 0;
    for (int y = 0; y < int'(VA); y++)
      for (int x = 0; x < int'(HA); x++) if (mem[{1'b0, 9'(y), 10'(x)}] !== 16'h001F) bad++;
    for (int i = 0; i < nc; i++) if (mem[{1'b0, 9'(i), 10'(20 + i)}] !== 16'hC000 + 16'(i)) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL clr_mem got %0d bad words want 0", bad); end
  endtask

  task automatic test_deferred_swap;
    int bad = 0;
    int p;
    wait_ph(0);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    wait_ph(0); wait_ph(0);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    wait_ph(0);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    for (p = 0; p < 300; p++) begin
      wait_ph(0);
      if (!clear_busy) break;
      if (df !== exp_df || sp !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0 || p >= 300) begin
      n_fail++; $display("FAIL defer_hold got %0d bad periods (p=%0d) want 0", bad, p);
    end
    n_tests++;
    if (df !== exp_df || sp !== 1'b1) begin
      n_fail++; $display("FAIL defer_at_fall got df=%b sp=%b want df=%b sp=1", df, sp, exp_df);
    end
    wait_ph(0);
    exp_df = ~exp_df;
    n_tests++;
    if (df !== exp_df || sp !== 1'b0) begin
      n_fail++; $display("FAIL defer_toggle got df=%b sp=%b want df=%b sp=0", df, sp, exp_df);
    end
    repeat (3) wait_ph(0);
    n_tests++;
    if (df !== exp_df) begin n_fail++; $display("FAIL defer_once got df=%b want %b", df, exp_df); end
  endtask

  task automatic test_tick_on_swap_edge;
    wait_ph(0);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    wait_ph(3);
    frame_tick = 1'b1; @(negedge clk); frame_tick = 1'b0;
    exp_df = ~exp_df;
    n_tests++;
    if (df !== exp_df || sp !== 1'b1) begin
      n_fail++; $display("FAIL edge_tick got df=%b sp=%b want df=%b sp=1", df, sp, exp_df);
    end
    wait_ph(0);
    exp_df = ~exp_df;
    n_tests++;
    if (df !== exp_df || sp !== 1'b0) begin
      n_fail++; $display("FAIL edge_tick2 got df=%b sp=%b want df=%b sp=0", df, sp, exp_df);
    end
  endtask

  task automatic test_reset_midstrobe;
    wait_ph(0);
    wr_req = 2'b10; wr_x = {10'd1, 10'd0}; wr_y = {9'd1, 9'd0}; wr_data = {16'hBEEF, 16'h0};
    wait_ph(3);
    n_tests++;
    if (we_n !== 1'b0) begin n_fail++; $display("FAIL midstrobe_pre got we_n=%b want 0", we_n); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (we_n !== 1'b1 || oe_n !== 1'b1 || df !== 1'b0) begin
      n_fail++; $display("FAIL midstrobe_reset got we_n=%b oe_n=%b df=%b want 1 1 0", we_n, oe_n, df);
    end
    wr_req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_round_robin();
    test_swap();
    test_clear_priority();
    test_deferred_swap();
    test_tick_on_swap_edge();
    test_reset_midstrobe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_frame_arbiter.md
# sram_frame_arbiter

Parametrised successor to the fixed four-stage SRAM controller. Time-slices one asynchronous 16-bit SRAM between one VGA read port and NUM_WR round-robin write clients in a double-buffered frame store. Adds a hardware hidden-frame clear and a deferred buffer swap. All SRAM strobes are generated from a single clock, so the 25%-duty auxiliary clock is no longer needed. The block sits between the sprite/background renderers (write clients), the VGA scan-out (read port) and the board SRAM pins.

## Interface
- NUM_WR, 2: number of write clients (1..4).
- DW, 16: data width; equals SRAM_DQ width.
- XW, 10: X coordinate width.
- YW, 9: Y coordinate width.
- AW, 20: SRAM address width; must equal 1+YW+XW.
- H_ACTIVE, 640: clear extent in X.
- V_ACTIVE, 480: clear extent in Y.

Ports:
- sram_clk  in  1  100 MHz clock.
- reset_n  in  1  Asynchronous, active-low reset.
- frame_tick  in  1  One-cycle pulse requesting a buffer swap.
- wr_req  in  NUM_WR  Per-client write request (level signal).
- wr_x  in  NUM_WR*XW  Per-client X, packed; client i occupies bits [i*XW +: XW].
- wr_y  in  NUM_WR*YW  Per-client Y, packed the same way.
- wr_data  in  NUM_WR*DW  Per-client pixel data, packed the same way.
- wr_ack  out  NUM_WR  One-cycle grant pulse per client.
- rd_req  in  1  VGA read request (level signal).
- rd_x, rd_y  in  XW, YW  Read coordinates.
- rd_data  out  DW  Read pixel.
- rd_valid  out  1  One-cycle pulse when rd_data is valid.
- clear_start  in  1  Pulse that starts a hidden-frame clear.
- clear_data  in  DW  Fill value for the clear.
- clear_busy  out  1  High while a clear is running.
- display_frame  out  1  Frame index currently being read.
- swap_pending  out  1  High when a swap has been requested but not yet applied.
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  out  1  Tied to 0.
- SRAM_OE_N, SRAM_WE_N  out  1  Registered SRAM strobes.
- SRAM_ADDR  out  AW  Registered SRAM address.
- SRAM_DQ  inout  DW  Bidirectional SRAM data bus.

## Operation
- Address mapping is {frame, y[YW-1:0], x[XW-1:0]}. Reads use display_frame. Client and clear writes use ~display_frame.
- A 2-bit phase counter ph cycles 0→1→2→3→0. The phases are R_SETUP, R_STROBE, W_SETUP, W_STROBE.
- **Read slot (ph 0–1).** If rd_req is high when ph==3, the read address is latched into SRAM_ADDR for ph0–1 and SRAM_OE_N=0 during ph0–1. On the edge ending ph1, rd_data <= SRAM_DQ and rd_valid is asserted during ph2. If no read is latched, OE_N=1 and rd_data holds its value.
- **Write slot (ph 2–3).** Arbitration is sampled when ph==1.
  - The winner is the first requesting client after last_grant, searching upward and wrapping. On reset last_grant=NUM_WR-1, so client 0 wins first.
  - The winner's address and data are registered for ph2–3. wr_ack[winner] pulses during ph2 and last_grant updates. The client may change its inputs from ph3 onward.
- **Clear fallback.** If no client requests and clear_busy=1, the slot writes clear_data at (cx,cy). Clients always have priority over the clear.
- **Strobes and data bus.** SRAM_WE_N=1 in ph2 and 0 in ph3 for an active write slot, and 1 otherwise. SRAM_DQ is driven in ph2–3 of an active write slot and is Z at all other times.
- **Clear sequencing.**
  - clear_start while clear_busy=0 sets busy and cx=cy=0.
  - Each clear write increments cx. At cx=H_ACTIVE-1, cx wraps to 0 and cy increments.
  - The write at (H_ACTIVE-1, V_ACTIVE-1) clears busy on the edge ending that ph3.
  - clear_start while busy is ignored.
- **Swap.**
  - frame_tick sets swap_pending.
  - display_frame toggles on the edge ending ph3 when swap_pending=1 and clear_busy=0. swap_pending clears on the same edge.
  - A swap requested during a clear is deferred until the clear completes.
  - frame_tick while swap_pending=1 has no additional effect; at most one swap is pending.
  - frame_tick arriving on the same cycle as the swap edge leaves swap_pending=1.

## Timing
- Reset values: OE_N=1, WE_N=1, DQ=Z, SRAM_ADDR=0, rd_data=0, rd_valid=0, wr_ack=0, display_frame=0, swap_pending=0, clear_busy=0, ph=0. Reset asserted mid-strobe forces WE_N high asynchronously. CE_N, UB_N and LB_N are constant 0.
- The period is 4 cycles: one read and one write per period, giving 25 M reads/s and 25 M writes/s.
- Read latency: rd_req sampled at ph3 → rd_valid 3 cycles later (ph2). rd_req must be held until rd_valid.
- Write grant: wr_req must be high at ph1 to win the following write slot. A client's worst-case wait is NUM_WR periods.
- SRAM_ADDR and DQ are stable for the full 2-cycle slot. WE_N is low for exactly one cycle, with one cycle of address setup before it and zero hold time after.
- All outputs are registered; no combinational path runs from inputs to SRAM pins.

## Test plan
- **Reset state.** Hold reset_n=0, then release → OE_N=1, WE_N=1, DQ=Z, display_frame=0, all acks 0. Asserting reset_n=0 while WE_N=0 drives WE_N=1 the same cycle.
- **Read path.** Preload SRAM model {0, y=5, x=7}=16'hA5A5, set rd_req=1, rd_x=7, rd_y=5 → rd_valid pulses in ph2 with rd_data=16'hA5A5; latency is 3 cycles after the ph3 sample.
- **Round robin.** NUM_WR=2 with both wr_req held high → acks alternate 0,1,0,1 in successive periods. Data 16'h1111 lands at address {1,y0,x0} and 16'h2222 at {1,y1,x1}. WE_N is low only in ph3.
- **Clear and priority.** Pulse clear_start with clear_data=16'h001F while client 0 requests every other period → clear writes occupy only the free slots. The SRAM model ends with all 640×480 hidden-frame words equal to 16'h001F except the client-written addresses. clear_busy falls after the last write, at (639,479).
- **Deferred swap.** frame_tick during a clear → swap_pending=1 and display_frame is unchanged until clear_busy falls, then toggles at the next ph3 edge. A second frame_tick while pending causes only one toggle.
- **Swap timing.** frame_tick with no clear running → display_frame toggles at the first ph3 edge. The next read addresses {1,..} and the next write addresses {0,..}.
